// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int PTR_WIDTH     = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  r_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CNT_W = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Status flags come straight from the registered count so they move with it.
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc;
        overflow_d  = w_en && !wr_acc;
        underflow_d = r_en && !rd_acc;

        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(1);
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale words are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized bench for sync_fifo, checked against a queue-based
// model of the FIFO's acceptance, ordering and flag rules.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [DW-1:0] wr_data;
    logic          r_en;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [PW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_unf;

    sync_fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .PTR_WIDTH    (PW),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .wr_data     (wr_data),
        .r_en        (r_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the FIFO's acceptance rules.
    task automatic model_edge(input logic do_rst, input logic w, input logic [DW-1:0] d, input logic r);
        int  occ;
        bit  rd_ok;
        bit  wr_ok;
        if (do_rst) begin
            m_q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            return;
        end
        occ   = m_q.size();
        rd_ok = r && (occ > 0);
        wr_ok = w && ((occ < DEPTH) || rd_ok);
        m_rd_valid = rd_ok;
        if (rd_ok) m_rd_data = m_q.pop_front();
        if (wr_ok) m_q.push_back(d);
        m_ovf = w && !wr_ok;
        m_unf = r && !rd_ok;
    endtask

    task automatic check_all(input string tag);
        int occ;
        occ = m_q.size();
        check({tag, ".count"},    32'(count),        32'(occ));
        check({tag, ".empty"},    32'(empty),        32'(occ == 0));
        check({tag, ".full"},     32'(full),         32'(occ == DEPTH));
        check({tag, ".afull"},    32'(almost_full),  32'(occ >= AF));
        check({tag, ".aempty"},   32'(almost_empty), 32'(occ <= AE));
        check({tag, ".rd_valid"}, 32'(rd_valid),     32'(m_rd_valid));
        check({tag, ".rd_data"},  32'(rd_data),      32'(m_rd_data));
        check({tag, ".overflow"}, 32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"},32'(underflow),    32'(m_unf));
    endtask

    // Drive one cycle of inputs, clock it, then sample #1 after the edge.
    task automatic cycle(input string tag, input logic do_rst, input logic w,
                         input logic [DW-1:0] d, input logic r);
        rst     = do_rst;
        w_en    = w;
        wr_data = d;
        r_en    = r;
        @(posedge clk);
        #1;
        model_edge(do_rst, w, d, r);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; wr_data = '0; r_en = 1'b0;
        #2;

        // Reset state, with a write request that reset must override
        cycle("reset", 1'b1, 1'b1, 8'h99, 1'b0);
        cycle("reset_idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Three writes, three reads in order
        cycle("w11", 1'b0, 1'b1, 8'h11, 1'b0);
        cycle("w22", 1'b0, 1'b1, 8'h22, 1'b0);
        cycle("w33", 1'b0, 1'b1, 8'h33, 1'b0);
        cycle("r0",  1'b0, 1'b0, 8'h00, 1'b1);
        check("basic.first", 32'(rd_data), 32'h11);
        cycle("r1",  1'b0, 1'b0, 8'h00, 1'b1);
        cycle("r2",  1'b0, 1'b0, 8'h00, 1'b1);
        check("basic.third", 32'(rd_data), 32'h33);
        cycle("r_idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to full, then overflow and drain
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b0, 1'b1, DW'(8'h40 + i), 1'b0);
        check("fill.full", 32'(full), 32'd1);
        cycle("ovf",      1'b0, 1'b1, 8'hFF, 1'b0);
        check("ovf.pulse", 32'(overflow), 32'd1);
        cycle("ovf_idle", 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b0, 8'h00, 1'b1);
        check("drain.last", 32'(rd_data), 32'h47);
        cycle("drain_idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Underflow on empty, then read+write on empty (no bypass)
        cycle("unf",    1'b0, 1'b0, 8'h00, 1'b1);
        cycle("unf_rw", 1'b0, 1'b1, 8'hA5, 1'b1);
        check("unf_rw.count", 32'(count), 32'd1);
        cycle("rd_a5",  1'b0, 1'b0, 8'h00, 1'b1);
        check("rd_a5.data", 32'(rd_data), 32'hA5);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b0, 1'b1, DW'(8'h80 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle("full_rw", 1'b0, 1'b1, DW'(8'hC0 + i), 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 1'b0, 8'h00, 1'b1);

        // Interleaved writes and reads across several pointer wraps
        for (int i = 0; i < 20; i++) begin
            cycle("il_w", 1'b0, 1'b1, DW'(i * 7 + 3), 1'b0);
            cycle("il_r", 1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'b0, 1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 50));
        end

        // Mid-operation reset discards content
        cycle("pre_rst_drain", 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle("w5", 1'b0, 1'b1, DW'(8'h50 + i), 1'b0);
        cycle("mid_rst", 1'b1, 1'b1, 8'hEE, 1'b1);
        check("mid_rst.rd_data", 32'(rd_data), 32'h00);
        cycle("post_rst_rd", 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst.unf", 32'(underflow), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
